// File: rtl/objeto_rect_multi_pkg.sv
// objeto_rect_multi_pkg
//   Shared definitions for the multi-rectangle screen object: index width,
//   the maximum rectangle count, the blink phase type and the priority
//   helper used by the output stage.
//
//   Rect record field order (MSB..LSB), used by the top-level record type:
//     en, blink, color, y1, y0, x1, x0
package objeto_rect_multi_pkg;

  localparam int NUM_RECT_MAX = 16;
  localparam int IDX_W        = 4;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_HIDDEN  = 1'b1
  } blink_phase_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_RECT_MAX-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_RECT_MAX - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/objeto_rect_multi_if.sv
// objeto_rect_multi_if
//   Pixel, configuration and result signals of objeto_rect_multi.
//   master : drives coordinates/config, receives colour results
//   slave  : the rectangle object itself
//   Pixel in : x, y, px_valid, frame_tick
//   Config   : cfg_we, cfg_idx, cfg_x0/x1, cfg_y0/y1, cfg_color, cfg_en, cfg_blink
//   Result   : color_out, activo, hit_idx, out_valid
interface objeto_rect_multi_if
  import objeto_rect_multi_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               px_valid;
  logic               frame_tick;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [X_W-1:0]     cfg_x0;
  logic [X_W-1:0]     cfg_x1;
  logic [Y_W-1:0]     cfg_y0;
  logic [Y_W-1:0]     cfg_y1;
  logic [COLOR_W-1:0] cfg_color;
  logic               cfg_en;
  logic               cfg_blink;
  logic [COLOR_W-1:0] color_out;
  logic               activo;
  logic [IDX_W-1:0]   hit_idx;
  logic               out_valid;

  modport master (
    output x, y, px_valid, frame_tick,
    output cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color, cfg_en, cfg_blink,
    input  color_out, activo, hit_idx, out_valid
  );

  modport slave (
    input  x, y, px_valid, frame_tick,
    input  cfg_we, cfg_idx, cfg_x0, cfg_x1, cfg_y0, cfg_y1, cfg_color, cfg_en, cfg_blink,
    output color_out, activo, hit_idx, out_valid
  );
endinterface

// File: rtl/objeto_rect_multi_rect_hit_cmp.sv
// rect_hit_cmp
//   Combinational coverage test for one rectangle: inclusive unsigned bounds
//   check gated by the enable and by the blink flag/phase.
//   Inputs : x, y pixel; x0..x1, y0..y1 bounds; en, blink, phase
//   Output : hit
//   An inverted range (x0>x1 or y0>y1) can never satisfy both compares, so it
//   never hits without any extra logic.
module rect_hit_cmp
  import objeto_rect_multi_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic           en,
  input  logic           blink,
  input  blink_phase_e   phase,
  output logic           hit
);
  logic in_x;
  logic in_y;
  logic hidden;

  assign in_x   = (x >= x0) && (x <= x1);
  assign in_y   = (y >= y0) && (y <= y1);
  assign hidden = blink && (phase == PH_HIDDEN);
  assign hit    = en && in_x && in_y && !hidden;
endmodule

// File: rtl/objeto_rect_multi.sv
// objeto_rect_multi
//   NUM_RECT configurable rectangles for the VGA pixel path. Config writes
//   land in shadow records and are copied to the active records on
//   frame_tick, so a frame never shows a half-written rectangle. Each pixel
//   goes through two register stages: stage 1 captures the per-rectangle hit
//   vector and colours, stage 2 picks the lowest-index hit.
//   Ports: clk pixel clock; reset async active-low; bus (slave modport) with
//   pixel inputs, config write port and colour/hit results.
module objeto_rect_multi
  import objeto_rect_multi_pkg::*;
#(
  parameter int NUM_RECT     = 4,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int COLOR_W      = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  objeto_rect_multi_if.slave bus
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic               en;
    logic               blink;
    logic [COLOR_W-1:0] color;
    logic [Y_W-1:0]     y1;
    logic [Y_W-1:0]     y0;
    logic [X_W-1:0]     x1;
    logic [X_W-1:0]     x0;
  } rect_t;

  rect_t shadow_q [NUM_RECT];
  rect_t shadow_d [NUM_RECT];
  rect_t active_q [NUM_RECT];
  rect_t active_d [NUM_RECT];
  rect_t wr_rec;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e     phase_q, phase_d;

  logic [NUM_RECT-1:0] hit_vec;
  logic [NUM_RECT-1:0] hit_s1_q, hit_s1_d;
  logic [COLOR_W-1:0]  color_s1_q [NUM_RECT];
  logic [COLOR_W-1:0]  color_s1_d [NUM_RECT];
  logic                vld_s1_q, vld_s1_d;

  logic [IDX_W-1:0]    win_idx;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                activo_q, activo_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                vld_s2_q, vld_s2_d;

  // Shadow write and commit. The commit copies shadow_d, not shadow_q, so a
  // write landing in the frame_tick cycle is part of the committed frame.
  // An out-of-range cfg_idx matches no entry and is dropped.
  always_comb begin
    wr_rec.en    = bus.cfg_en;
    wr_rec.blink = bus.cfg_blink;
    wr_rec.color = bus.cfg_color;
    wr_rec.y1    = bus.cfg_y1;
    wr_rec.y0    = bus.cfg_y0;
    wr_rec.x1    = bus.cfg_x1;
    wr_rec.x0    = bus.cfg_x0;
    for (int i = 0; i < NUM_RECT; i++) begin
      shadow_d[i] = shadow_q[i];
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) shadow_d[i] = wr_rec;
      active_d[i] = bus.frame_tick ? shadow_d[i] : active_q[i];
    end
  end

  // Blink timebase: advances only on frame_tick; the phase flips each time
  // the counter wraps from BLINK_FRAMES-1 back to 0.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (bus.frame_tick) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = blink_phase_e'(~phase_q);
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // One comparator per rectangle against the active (committed) records.
  for (genvar gi = 0; gi < NUM_RECT; gi++) begin : g_cmp
    rect_hit_cmp #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_cmp (
      .x     (bus.x),
      .y     (bus.y),
      .x0    (active_q[gi].x0),
      .x1    (active_q[gi].x1),
      .y0    (active_q[gi].y0),
      .y1    (active_q[gi].y1),
      .en    (active_q[gi].en),
      .blink (active_q[gi].blink),
      .phase (phase_q),
      .hit   (hit_vec[gi])
    );
  end

  // Stage 1 captures colours alongside the hits so an in-flight pixel is
  // unaffected by a commit happening one cycle later.
  always_comb begin
    hit_s1_d = hit_vec;
    vld_s1_d = bus.px_valid;
    for (int i = 0; i < NUM_RECT; i++) begin
      color_s1_d[i] = active_q[i].color;
    end
  end

  // Stage 2: lowest index wins.
  assign win_idx = lowest_set(NUM_RECT_MAX'(hit_s1_q));

  always_comb begin
    activo_d  = |hit_s1_q;
    hit_idx_d = activo_d ? win_idx : '0;
    vld_s2_d  = vld_s1_q;
    color_d   = '0;
    for (int i = 0; i < NUM_RECT; i++) begin
      if (activo_d && (win_idx == IDX_W'(i))) color_d = color_s1_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i]   <= '0;
        active_q[i]   <= '0;
        color_s1_q[i] <= '0;
      end
      blink_cnt_q <= '0;
      phase_q     <= PH_VISIBLE;
      hit_s1_q    <= '0;
      vld_s1_q    <= 1'b0;
      color_q     <= '0;
      activo_q    <= 1'b0;
      hit_idx_q   <= '0;
      vld_s2_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i]   <= shadow_d[i];
        active_q[i]   <= active_d[i];
        color_s1_q[i] <= color_s1_d[i];
      end
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hit_s1_q    <= hit_s1_d;
      vld_s1_q    <= vld_s1_d;
      color_q     <= color_d;
      activo_q    <= activo_d;
      hit_idx_q   <= hit_idx_d;
      vld_s2_q    <= vld_s2_d;
    end
  end

  assign bus.color_out = color_q;
  assign bus.activo    = activo_q;
  assign bus.hit_idx   = hit_idx_q;
  assign bus.out_valid = vld_s2_q;

endmodule

// File: tb/tb_objeto_rect_multi.sv
// tb_objeto_rect_multi
//   Directed-vector bench for objeto_rect_multi (NUM_RECT=4, BLINK_FRAMES=2).
//   Inputs change 1 time unit after the rising edge; outputs are read at the
//   same offset. Expected values are written by hand into each call.
module tb_objeto_rect_multi;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  objeto_rect_multi_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus ();

  objeto_rect_multi #(
    .NUM_RECT     (4),
    .X_W          (8),
    .Y_W          (7),
    .COLOR_W      (3),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    $display("tick");
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] x0, input logic [7:0] x1,
                    input logic [6:0] y0, input logic [6:0] y1, input logic [2:0] col,
                    input logic en, input logic blk, input logic tk);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = idx;
    bus.cfg_x0    = x0;
    bus.cfg_x1    = x1;
    bus.cfg_y0    = y0;
    bus.cfg_y1    = y1;
    bus.cfg_color = col;
    bus.cfg_en    = en;
    bus.cfg_blink = blk;
    bus.frame_tick = tk;
    step();
    bus.cfg_we     = 1'b0;
    bus.frame_tick = 1'b0;
    $display("wr idx=%0d x=%0d..%0d y=%0d..%0d col=%0d en=%0b blink=%0b tick=%0b",
             idx, x0, x1, y0, y1, col, en, blk, tk);
  endtask

  // Single pixel: out_valid must still be low one edge later, and the
  // result must appear exactly two edges after the pixel is presented.
  task automatic pix(input logic [7:0] px, input logic [6:0] py, input logic e_act,
                     input logic [2:0] e_col, input logic [3:0] e_idx, input string tag);
    bus.x        = px;
    bus.y        = py;
    bus.px_valid = 1'b1;
    step();
    chk({tag, "/ov1"}, bus.out_valid, 0);
    bus.px_valid = 1'b0;
    step();
    chk({tag, "/ov2"}, bus.out_valid, 1);
    chk({tag, "/act"}, bus.activo, e_act);
    chk({tag, "/col"}, bus.color_out, e_col);
    chk({tag, "/idx"}, bus.hit_idx, e_idx);
    $display("pix %s (%0d,%0d) act=%0b col=%0d idx=%0d", tag, px, py,
             bus.activo, bus.color_out, bus.hit_idx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/act"}, bus.activo, 0);
    chk({tag, "/col"}, bus.color_out, 0);
    chk({tag, "/idx"}, bus.hit_idx, 0);
    chk({tag, "/ov"},  bus.out_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    #3 reset = 1'b1;
    step();
    $display("reset pulse");
  endtask

  localparam logic [4:0] BLINK_VIS = 5'b01100; // ticks 2..6, bit k-2

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset          = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.px_valid   = 1'b0;
    bus.frame_tick = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_x0     = '0;
    bus.cfg_x1     = '0;
    bus.cfg_y0     = '0;
    bus.cfg_y1     = '0;
    bus.cfg_color  = '0;
    bus.cfg_en     = 1'b0;
    bus.cfg_blink  = 1'b0;

    repeat (3) step();
    chk_zero("reset_state");
    #3 reset = 1'b1;
    step();

    // Nothing committed: every pixel of the line is empty.
    for (int i = 0; i < 256; i++) pix(8'(i), 7'd10, 1'b0, 3'd0, 4'd0, "sweep");

    // Full-width rectangle 0, bottom edge at y=20.
    wr(4'd0, 8'd0, 8'd255, 7'd0, 7'd20, 3'b101, 1'b1, 1'b0, 1'b0);
    pix(8'd255, 7'd20, 1'b0, 3'd0, 4'd0, "precommit");
    tick();
    pix(8'd255, 7'd20, 1'b1, 3'b101, 4'd0, "r0_corner");
    pix(8'd0,   7'd21, 1'b0, 3'd0,   4'd0, "r0_below");
    pix(8'd0,   7'd0,  1'b1, 3'b101, 4'd0, "r0_origin");

    // Overlap: rect0 wins where both cover.
    wr(4'd1, 8'd10, 8'd50, 7'd5, 7'd15, 3'b010, 1'b1, 1'b0, 1'b0);
    wr(4'd0, 8'd30, 8'd70, 7'd5, 7'd15, 3'b100, 1'b1, 1'b0, 1'b0);
    tick();
    pix(8'd40,  7'd10, 1'b1, 3'b100, 4'd0, "ovl_r0");
    pix(8'd20,  7'd10, 1'b1, 3'b010, 4'd1, "ovl_r1");
    pix(8'd70,  7'd15, 1'b1, 3'b100, 4'd0, "r0_edge");
    pix(8'd71,  7'd15, 1'b0, 3'd0,   4'd0, "r0_past");
    pix(8'd255, 7'd20, 1'b0, 3'd0,   4'd0, "old_r0");

    // Back-to-back pixels, one per clock.
    bus.x = 8'd40; bus.y = 7'd10; bus.px_valid = 1'b1;
    step();
    bus.x = 8'd20;
    step();
    chk("strm0/col", bus.color_out, 3'b100);
    chk("strm0/idx", bus.hit_idx, 0);
    chk("strm0/ov",  bus.out_valid, 1);
    bus.x = 8'd5;
    step();
    chk("strm1/col", bus.color_out, 3'b010);
    chk("strm1/idx", bus.hit_idx, 1);
    chk("strm1/act", bus.activo, 1);
    bus.px_valid = 1'b0;
    step();
    chk("strm2/act", bus.activo, 0);
    chk("strm2/ov",  bus.out_valid, 1);
    step();
    chk("strm3/ov",  bus.out_valid, 0);
    $display("stream 3 pixels");

    // Shadow write without commit, then write coinciding with frame_tick.
    wr(4'd2, 8'd100, 8'd120, 7'd40, 7'd50, 3'd7, 1'b1, 1'b0, 1'b0);
    pix(8'd110, 7'd45, 1'b0, 3'd0, 4'd0, "r2_shadow");
    wr(4'd2, 8'd100, 8'd120, 7'd40, 7'd50, 3'd6, 1'b1, 1'b0, 1'b1);
    pix(8'd110, 7'd45, 1'b1, 3'd6, 4'd2, "r2_same_tick");
    pix(8'd100, 7'd40, 1'b1, 3'd6, 4'd2, "r2_tl");
    pix(8'd120, 7'd50, 1'b1, 3'd6, 4'd2, "r2_br");
    pix(8'd99,  7'd45, 1'b0, 3'd0, 4'd0, "r2_left");
    pix(8'd121, 7'd45, 1'b0, 3'd0, 4'd0, "r2_right");
    pix(8'd110, 7'd51, 1'b0, 3'd0, 4'd0, "r2_below");
    pix(8'd110, 7'd39, 1'b0, 3'd0, 4'd0, "r2_above");

    // Out-of-range index must not touch any record.
    wr(4'd4, 8'd0, 8'd255, 7'd0, 7'd127, 3'd1, 1'b1, 1'b0, 1'b1);
    pix(8'd200, 7'd60, 1'b0, 3'd0,   4'd0, "idx4_ign");
    pix(8'd40,  7'd10, 1'b1, 3'b100, 4'd0, "idx4_r0");
    pix(8'd20,  7'd10, 1'b1, 3'b010, 4'd1, "idx4_r1");

    // Inverted x range never hits.
    wr(4'd3, 8'd90, 8'd80, 7'd0, 7'd100, 3'd3, 1'b1, 1'b0, 1'b1);
    pix(8'd85, 7'd10, 1'b0, 3'd0, 4'd0, "inv_mid");
    pix(8'd80, 7'd10, 1'b0, 3'd0, 4'd0, "inv_x1");
    pix(8'd90, 7'd10, 1'b0, 3'd0, 4'd0, "inv_x0");

    // Blink: fresh reset so the counter starts at 0. rect0 blinks over
    // rect1; the commit write is tick 1.
    do_reset();
    wr(4'd0, 8'd0, 8'd50,  7'd0, 7'd50, 3'd5, 1'b1, 1'b1, 1'b0);
    wr(4'd1, 8'd0, 8'd100, 7'd0, 7'd50, 3'd3, 1'b1, 1'b0, 1'b1);
    pix(8'd10, 7'd10, 1'b1, 3'd5, 4'd0, "blink_t1");
    pix(8'd70, 7'd10, 1'b1, 3'd3, 4'd1, "steady_t1");
    for (int k = 0; k < 5; k++) begin
      tick();
      if (BLINK_VIS[k]) pix(8'd10, 7'd10, 1'b1, 3'd5, 4'd0, "blink_vis");
      else              pix(8'd10, 7'd10, 1'b1, 3'd3, 4'd1, "blink_hid");
      pix(8'd70, 7'd10, 1'b1, 3'd3, 4'd1, "steady");
    end

    // Reset mid-stream with a second pixel in flight.
    bus.x = 8'd70; bus.y = 7'd10; bus.px_valid = 1'b1;
    step();
    step();
    chk("pre_rst/act", bus.activo, 1);
    chk("pre_rst/col", bus.color_out, 3);
    chk("pre_rst/idx", bus.hit_idx, 1);
    bus.px_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("rst_async");
    step();
    chk_zero("rst_flush");
    #3 reset = 1'b1;
    step();
    $display("reset mid-stream");
    pix(8'd70, 7'd10, 1'b0, 3'd0, 4'd0, "post_rst_r1");
    pix(8'd10, 7'd10, 1'b0, 3'd0, 4'd0, "post_rst_r0");
    wr(4'd0, 8'd0, 8'd10, 7'd0, 7'd10, 3'd1, 1'b1, 1'b0, 1'b1);
    pix(8'd5,  7'd5,  1'b1, 3'd1, 4'd0, "rewrite_r0");
    pix(8'd70, 7'd10, 1'b0, 3'd0, 4'd0, "rewrite_r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/objeto_rect_multi.md
Name: objeto_rect_multi

Overview:
Parametrised multi-rectangle screen object for the VGA pixel path. It holds NUM_RECT runtime-configurable rectangles, each with its own bounds, colour, enable and blink flag. For every incoming pixel coordinate it returns the colour of the highest-priority covering rectangle through a 2-stage pipeline. Configuration goes to shadow registers and is committed only on the frame tick, so a frame never shows a partial update. Sits beside the other screen objects and feeds the colour mux ahead of the VGA output.

Parameters:
NUM_RECT, 4, number of rectangles (1..16); index 0 has highest priority
X_W, 8, pixel x coordinate width
Y_W, 7, pixel y coordinate width
COLOR_W, 3, colour width
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
x  in  X_W  current pixel x
y  in  Y_W  current pixel y
px_valid  in  1  x/y valid this cycle
frame_tick  in  1  one-cycle pulse at start of vertical blank
cfg_we  in  1  shadow write strobe
cfg_idx  in  4  rectangle index to write
cfg_x0  in  X_W  left bound, inclusive
cfg_x1  in  X_W  right bound, inclusive
cfg_y0  in  Y_W  top bound, inclusive
cfg_y1  in  Y_W  bottom bound, inclusive
cfg_color  in  COLOR_W  rectangle colour
cfg_en  in  1  rectangle enable
cfg_blink  in  1  rectangle blinks
color_out  out  COLOR_W  colour of winning rectangle, 0 if none
activo  out  1  some rectangle covers the pixel
hit_idx  out  4  index of winning rectangle, 0 if none
out_valid  out  1  px_valid delayed 2 cycles

Behaviour:
- Reset (reset=0, asynchronous): every shadow and active record cleared (en=0, blink=0, bounds=0, colour=0). Blink counter=0, blink phase=0 (visible). All pipeline registers and all outputs = 0.
- Config write: cfg_we=1 with cfg_idx<NUM_RECT loads all fields of shadow[cfg_idx] at the clock edge. cfg_idx>=NUM_RECT: write ignored, no state change.
- Commit: on frame_tick, active[i] <= shadow[i] for all i. If cfg_we and frame_tick occur in the same cycle, the write is included in the commit (active takes the post-write shadow value).
- Blink: on each frame_tick the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles. The counter and phase change only on frame_tick.
- Hit rule: rect i hits when en_i, x0_i<=x<=x1_i, y0_i<=y<=y1_i, and not (blink_i and phase=1). Compares are unsigned and inclusive. If x0>x1 or y0>y1, the rectangle never hits. No wrap-around.
- Stage 1 (cycle N+1): register the hit vector[NUM_RECT], the colours, and px_valid.
- Stage 2 (cycle N+2): the lowest set index wins. color_out=colour of the winner, activo=1, hit_idx=winner. With no hit: color_out=0, activo=0, hit_idx=0.
- out_valid = px_valid delayed 2 cycles. Outputs are computed regardless of px_valid; downstream must gate on out_valid.
- Latency is fixed at 2 clocks. Throughput is one pixel per clock with no stalls.
- Active registers change only on frame_tick. Pixels already in flight use the values sampled at stage 1.
- Reset mid-frame clears the pipeline immediately. The first valid output appears 2 cycles after reset is released and px_valid is asserted.

Decomposition:
- Shared package/include: field widths, NUM_RECT_MAX=16, and the record field ordering for rect config.
- One sub-module, rect_hit_cmp: the combinational inclusive bounds check plus enable/blink gating for a single rectangle, instantiated NUM_RECT times via generate.
- Shadow/active storage, blink counter, priority encoder and pipeline live in the top module.

Test Plan:
- Reset, then sweep x=0..255 at y=10 with no commit -> activo=0 and color_out=0 for every pixel, out_valid follows px_valid by exactly 2 cycles.
- Write rect0 = (0,300→clipped to 255, 0,20, colour 3'b101, en) and commit with frame_tick. Pixel (255,20) -> colour 101, activo=1, hit_idx=0. Pixel (0,21) -> activo=0.
- Write rect1 (10..50, 5..15, colour 010) and rect0 (30..70, 5..15, colour 100), then commit. Pixel (40,10) -> colour 100, hit_idx=0. Pixel (20,10) -> colour 010, hit_idx=1.
- Write rect2 without frame_tick -> no change at (x,y) inside it. Assert cfg_we together with frame_tick -> the new value is visible from the next pixel. Write with cfg_idx=NUM_RECT -> no effect.
- Set blink flag with BLINK_FRAMES=2 and issue frame_ticks -> the rect is visible for 2 frames, hidden for 2, and so on. A non-blink rect is unaffected.
- Assert reset mid-stream with a hit in flight -> outputs 0 immediately (asynchronously), and all rects are disabled after release until a new write and commit.
